c_writeback_merger: RTL and testbench

// Downstream of the composed 16x16 matmul. Captures the two 8-lane C output streams (tile 0_1, tile 1_1),

---
 rtl/c_writeback_merger_if.sv | 34 +++
 rtl/c_writeback_merger.sv | 155 +++++++++++++++
 tb/tb_c_writeback_merger.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c_writeback_merger_if.sv
// Bus bundle for c_writeback_merger: operation control, the two C row streams,
// the merged C-memory write port and status flags.
interface c_writeback_merger_if #(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned MAT_MUL_SIZE = 8,
    parameter int unsigned AWIDTH       = 10
);
    localparam int unsigned DW = DWIDTH * MAT_MUL_SIZE;

    logic              start;
    logic [DW-1:0]     c_data_0;
    logic [AWIDTH-1:0] c_addr_0;
    logic              c_valid_0;
    logic [DW-1:0]     c_data_1;
    logic [AWIDTH-1:0] c_addr_1;
    logic              c_valid_1;
    logic              wr_ready;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, c_data_0, c_addr_0, c_valid_0, c_data_1, c_addr_1, c_valid_1, wr_ready,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, c_data_0, c_addr_0, c_valid_0, c_data_1, c_addr_1, c_valid_1, wr_ready,
        output wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/c_writeback_merger.sv
// Captures two non-stallable C row streams into small FIFOs and round-robin merges them
// onto a single registered C-memory write port. Reports done once every row is written.
module c_writeback_merger #(
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned MAT_MUL_SIZE  = 8,
    parameter int unsigned AWIDTH        = 10,
    parameter int unsigned FIFO_DEPTH    = 4,   // power of 2, at least 2
    parameter int unsigned ROWS_PER_TILE = 8
) (
    input logic                clk,
    input logic                resetn,
    c_writeback_merger_if.slave bus
);
    localparam int unsigned DW = DWIDTH * MAT_MUL_SIZE;
    localparam int unsigned EW = AWIDTH + DW;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(ROWS_PER_TILE + 1);
    localparam logic [CW-1:0] RowsMax  = CW'(ROWS_PER_TILE);
    localparam logic [PW:0]   FifoFull = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic              busy_q, done_q, err_q;
    logic [1:0][CW-1:0] row_cnt_q;

    logic [EW-1:0]      fifo_mem [2][FIFO_DEPTH];
    logic [1:0][PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [1:0][PW:0]   fifo_cnt_q;

    logic              wr_en_q;
    logic [AWIDTH-1:0] wr_addr_q;
    logic [DW-1:0]     wr_data_q;
    logic              rr_q;    // 1: stream 1 wins the next tie

    logic [1:0]         beat_valid, fifo_empty, fifo_full, pop, push, counted, beat_err;
    logic [1:0][EW-1:0] beat_entry, fifo_head;
    logic               load, in_run, start_go, drain_done;

    // Capture qualification, arbitration and FSM conditions.
    always_comb begin
        beat_valid    = {bus.c_valid_1, bus.c_valid_0};
        beat_entry[0] = {bus.c_addr_0, bus.c_data_0};
        beat_entry[1] = {bus.c_addr_1, bus.c_data_1};
        in_run        = (state_q == StRun);
        load          = !wr_en_q || bus.wr_ready;
        for (int s = 0; s < 2; s++) begin
            fifo_empty[s] = (fifo_cnt_q[s] == '0);
            fifo_full[s]  = (fifo_cnt_q[s] == FifoFull);
            fifo_head[s]  = fifo_mem[s][rd_ptr_q[s]];
        end
        pop[0] = load && !fifo_empty[0] && (fifo_empty[1] || !rr_q);
        pop[1] = load && !fifo_empty[1] && (fifo_empty[0] || rr_q);
        for (int s = 0; s < 2; s++) begin
            // Every in-RUN beat below the row limit counts, even one lost to overflow,
            // so a dropped row cannot stall completion.
            counted[s]  = beat_valid[s] && in_run && (row_cnt_q[s] != RowsMax);
            // A full FIFO still takes a beat when it is popped on the same cycle.
            push[s]     = counted[s] && (!fifo_full[s] || pop[s]);
            beat_err[s] = beat_valid[s] && !push[s];
        end
        start_go   = bus.start && ((state_q == StIdle) || (state_q == StDone));
        drain_done = fifo_empty[0] && fifo_empty[1] && load;
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) fifo_mem[s][wr_ptr_q[s]] <= beat_entry[s];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
                if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
                fifo_cnt_q[s] <= fifo_cnt_q[s] + (PW + 1)'(push[s]) - (PW + 1)'(pop[s]);
            end
        end
    end

    // Output write register and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_q      <= 1'b0;
        end else if (load) begin
            wr_en_q <= |pop;
            if (pop[0]) begin
                {wr_addr_q, wr_data_q} <= fifo_head[0];
            end else if (pop[1]) begin
                {wr_addr_q, wr_data_q} <= fifo_head[1];
            end
            // Point at the stream that did not win.
            if (|pop) rr_q <= pop[0];
        end
    end

    // Operation FSM with registered status outputs and row counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            row_cnt_q <= '0;
        end else begin
            err_q <= (err_q && !start_go) || (|beat_err);
            for (int s = 0; s < 2; s++) begin
                if (start_go) begin
                    row_cnt_q[s] <= '0;
                end else if (counted[s]) begin
                    row_cnt_q[s] <= row_cnt_q[s] + CW'(1);
                end
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_go) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if ((row_cnt_q[0] == RowsMax) && (row_cnt_q[1] == RowsMax)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_c_writeback_merger.sv
// Self-checking bench for c_writeback_merger: a scoreboard of expected writes per stream,
// consumed by a write-port monitor, plus per-scenario inline checks.
module tb_c_writeback_merger;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned EW = AW + DW;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    c_writeback_merger_if bus ();

    c_writeback_merger dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int seq_log[$];
    int wr_count = 0;
    bit mon_en = 1'b0;

    int mon_s;
    logic [EW-1:0] mon_got, mon_exp;

    // Write-port monitor: every accepted write must match the head of its stream's queue.
    // The stream id is carried in data[63:56] of every beat the bench generates.
    always @(negedge clk) begin
        if (mon_en && resetn && bus.wr_en && bus.wr_ready) begin
            mon_s   = int'(bus.wr_data[56]);
            mon_got = {bus.wr_addr, bus.wr_data};
            wr_count++;
            seq_log.push_back(mon_s);
            vectors++;
            if ((mon_s == 0 && exp_q0.size() == 0) || (mon_s == 1 && exp_q1.size() == 0)) begin
                miscompares++;
                $display("FAIL write_unexpected: got %h, required no write", mon_got);
            end else begin
                if (mon_s == 0) mon_exp = exp_q0.pop_front();
                else            mon_exp = exp_q1.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write_data s%0d: got %h, required %h", mon_s, mon_got, mon_exp);
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk_data(input int s, input int a);
        return {8'(s), 8'(a), 32'($urandom), 16'hC0DE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int s, input int a, input bit ok, output logic [DW-1:0] d);
        d = mk_data(s, a);
        if (s == 0) begin
            bus.c_valid_0 = 1'b1;
            bus.c_addr_0  = AW'(a);
            bus.c_data_0  = d;
            if (ok) exp_q0.push_back({AW'(a), d});
        end else begin
            bus.c_valid_1 = 1'b1;
            bus.c_addr_1  = AW'(a);
            bus.c_data_1  = d;
            if (ok) exp_q1.push_back({AW'(a), d});
        end
    endtask

    task automatic clr_beats();
        bus.c_valid_0 = 1'b0;
        bus.c_valid_1 = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_serial();
        logic [DW-1:0] d;
        bus.wr_ready = 1'b1;
        do_start();
        for (int c = 0; c < 19; c++) begin
            clr_beats();
            if (c < 16) set_beat((c < 8) ? 0 : 1, c, 1'b1, d);
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (bus.wr_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL serial_early: got wr_en=%b, required 0", bus.wr_en);
                end
            end
            if (c >= 2 && c < 18) begin
                vectors++;
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(c - 2)) begin
                    miscompares++;
                    $display("FAIL serial_latency c%0d: got en=%b addr=%0d, required 1 %0d",
                             c, bus.wr_en, bus.wr_addr, c - 2);
                end
            end
            if (c == 5) begin
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL serial_busy: got %b, required 1", bus.busy);
                end
            end
            if (c == 17 || c == 18) begin
                vectors++;
                if (bus.done !== (c == 18)) begin
                    miscompares++;
                    $display("FAIL serial_done c%0d: got %b, required %b", c, bus.done, c == 18);
                end
            end
            tick();
        end
        clr_beats();
        vectors++;
        if (bus.err !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL serial_end: got err=%b left=%0d/%0d, required 0 0/0",
                     bus.err, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        bit ok;
        int bad;
        do_start();
        seq_log.delete();
        for (int p = 0; p < 8; p++) begin
            set_beat(0, 2 * p, 1'b1, d);
            set_beat(1, 2 * p + 1, 1'b1, d);
            tick();
            clr_beats();
            tick();
        end
        wait_done(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL simul_done: got done=0 after budget, required 1");
        end
        // Previous operation ended on a stream-1 write, so stream 0 leads the interleave.
        bad = 0;
        foreach (seq_log[i]) if (seq_log[i] != (i % 2)) bad++;
        vectors++;
        if (seq_log.size() != 16 || bad != 0) begin
            miscompares++;
            $display("FAIL simul_interleave: got %0d writes %0d out of order, required 16 0",
                     seq_log.size(), bad);
        end
        vectors++;
        if (bus.err !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL simul_end: got err=%b left=%0d/%0d, required 0 0/0",
                     bus.err, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_excess();
        logic [DW-1:0] d;
        bit ok;
        int base;
        base = wr_count;
        set_beat(0, 250, 1'b0, d);
        tick();
        clr_beats();
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b1 || bus.wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_beat: got err=%b wr_en=%b, required 1 0", bus.err, bus.wr_en);
        end
        tick();
        do_start();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL start_clears_err: got %b, required 0", bus.err);
        end
        for (int c = 0; c < 17; c++) begin
            clr_beats();
            set_beat((c < 8) ? 0 : 1, 200 + c, c < 16, d);
            tick();
        end
        clr_beats();
        wait_done(40, ok);
        vectors++;
        if (!ok || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL excess_beat: got done=%b err=%b, required 1 1", ok, bus.err);
        end
        vectors++;
        if (wr_count - base != 16 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL excess_count: got %0d writes left=%0d/%0d, required 16 0/0",
                     wr_count - base, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] d, d0;
        bit ok;
        int bad;
        bus.wr_ready = 1'b0;
        do_start();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_start_err: got %b, required 0", bus.err);
        end
        bad = 0;
        // Beat 0 sits in the output register, beats 1..4 fill the FIFO, beat 5 is lost.
        for (int c = 0; c < 10; c++) begin
            clr_beats();
            if (c < 6) set_beat(0, 100 + c, c < 5, d);
            if (c == 0) d0 = d;
            @(negedge clk);
            if (c >= 2) begin
                vectors++;
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(100) || bus.wr_data !== d0) begin
                    bad++;
                    miscompares++;
                    $display("FAIL bp_hold c%0d: got en=%b addr=%0d data=%h, required 1 100 %h",
                             c, bus.wr_en, bus.wr_addr, bus.wr_data, d0);
                end
            end
            tick();
        end
        clr_beats();
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overflow_err: got %b, required 1", bus.err);
        end
        bus.wr_ready = 1'b1;
        repeat (8) tick();
        for (int c = 6; c < 16; c++) begin
            clr_beats();
            set_beat((c < 8) ? 0 : 1, 100 + c, 1'b1, d);
            tick();
        end
        clr_beats();
        wait_done(40, ok);
        vectors++;
        if (!ok || bus.err !== 1'b1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL bp_end: got done=%b err=%b left=%0d/%0d, required 1 1 0/0",
                     ok, bus.err, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] d;
        bit ok;
        bus.wr_ready = 1'b0;
        do_start();
        for (int c = 0; c < 16; c++) begin
            clr_beats();
            // FIFO 0 is full at c==5; the write port opens on the same cycle.
            if (c == 5) bus.wr_ready = 1'b1;
            set_beat((c < 8) ? 0 : 1, 300 + c, 1'b1, d);
            tick();
            if (c == 5) begin
                vectors++;
                if (bus.err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_pop_err: got %b, required 0", bus.err);
                end
            end
        end
        clr_beats();
        wait_done(40, ok);
        vectors++;
        if (!ok || bus.err !== 1'b0 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL full_pop_end: got done=%b err=%b left=%0d/%0d, required 1 0 0/0",
                     ok, bus.err, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] d;
        int base;
        bus.wr_ready = 1'b0;
        do_start();
        for (int c = 0; c < 4; c++) begin
            clr_beats();
            set_beat(0, 400 + c, 1'b1, d);
            tick();
        end
        clr_beats();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got en=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err);
        end
        exp_q0.delete();
        exp_q1.delete();
        base = wr_count;
        @(posedge clk);
        #1 resetn = 1'b1;
        bus.wr_ready = 1'b1;
        repeat (10) tick();
        vectors++;
        if (wr_count != base || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_after: got %0d writes busy=%b done=%b, required 0 0 0",
                     wr_count - base, bus.busy, bus.done);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.c_valid_0 = 1'b0;
        bus.c_addr_0  = '0;
        bus.c_data_0  = '0;
        bus.c_valid_1 = 1'b0;
        bus.c_addr_1  = '0;
        bus.c_data_1  = '0;
        bus.wr_ready  = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_serial();
        test_simultaneous();
        test_excess();
        test_back_pressure();
        test_full_pop();
        test_reset_mid_run();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
